// File: rtl/mux_arb_n.sv
// mux_arb_n -- registered N-to-1 channel selector with valid/ready handshakes.
//
// Picks one of NCH input channels each cycle, either by explicit index (mode = 0)
// or by round-robin arbitration among the valid channels (mode = 1). The chosen
// word is captured into a single output register, giving one cycle of latency at
// full throughput.
//
// Handshake semantics (both sides): a beat transfers on a rising edge where the
// producer's valid and the consumer's ready are both high. On the input side
// in_ready is at most one-hot and never depends on in_data. On the output side
// out_data/out_sel stay stable while out_valid = 1 and out_ready = 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       0 = explicit select via sel, 1 = round-robin
//   sel        channel index used in explicit mode (values >= NCH never grant)
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel offer
//   in_ready   per-channel accept (one-hot or zero)
//   out_data   registered selected data
//   out_sel    index of the channel held in out_data
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the held beat
module mux_arb_n #(
    parameter int WIDTH = 32,
    parameter int NCH   = 16,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Channel count and last index at the widths used for comparisons, so
    // non-power-of-two NCH wraps at NCH rather than at 2^SELW.
    localparam logic [SELW:0]   NCH_L   = (SELW + 1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q,  out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load;
    logic             sel_in_range;
    logic             rr_found;
    logic [SELW-1:0]  rr_idx;
    logic [SELW:0]    scan_idx;
    logic             grant_valid;
    logic [SELW-1:0]  grant_idx;

    // The output register can take a new beat when it is empty or its current
    // beat retires on this same edge.
    assign load = !out_valid_q || out_ready;

    assign sel_in_range = ({1'b0, sel} < NCH_L);

    // Round-robin scan: first valid channel starting at ptr, wrapping at NCH.
    // ptr < NCH, so ptr + k < 2*NCH and a single conditional subtract wraps it.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            scan_idx = {1'b0, ptr_q} + (SELW + 1)'(k);
            if (scan_idx >= NCH_L) begin
                scan_idx = scan_idx - NCH_L;
            end
            if (!rr_found && in_valid[scan_idx[SELW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx[SELW-1:0];
            end
        end
    end

    // Grant selection: only while the output register can load.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (load) begin
            if (mode) begin
                grant_valid = rr_found;
                grant_idx   = rr_idx;
            end else if (sel_in_range && in_valid[sel]) begin
                grant_valid = 1'b1;
                grant_idx   = sel;
            end
        end
    end

    // Accept strobe; suppressed during reset so no beat is taken and then lost.
    always_comb begin
        in_ready = '0;
        if (grant_valid && !rst) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state for the output register and the round-robin pointer.
    // A load with no grant empties the register but keeps data/index as they were.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_data_d = in_data[grant_idx*WIDTH +: WIDTH];
                out_sel_d  = grant_idx;
                // Pointer moves past the winner only for round-robin grants.
                if (mode) begin
                    ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: a 16x32 instance (a) and a 3x8 instance (b) share clock
// and reset. A reference model tracks each instance from the selection rules and
// is compared on every falling edge; directed phases add literal expectations.
module tb_mux_arb_n;

    logic clk;
    logic rst;

    // instance a: NCH = 16, WIDTH = 32
    logic         mode_a;
    logic [3:0]   sel_a;
    logic [511:0] in_data_a;
    logic [15:0]  in_valid_a;
    logic [15:0]  in_ready_a;
    logic [31:0]  out_data_a;
    logic [3:0]   out_sel_a;
    logic         out_valid_a;
    logic         out_ready_a;

    // instance b: NCH = 3, WIDTH = 8
    logic         mode_b;
    logic [1:0]   sel_b;
    logic [23:0]  in_data_b;
    logic [2:0]   in_valid_b;
    logic [2:0]   in_ready_b;
    logic [7:0]   out_data_b;
    logic [1:0]   out_sel_b;
    logic         out_valid_b;
    logic         out_ready_b;

    int checks;
    int failures;

    mux_arb_n #(.WIDTH(32), .NCH(16)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode_a),
        .sel       (sel_a),
        .in_data   (in_data_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .out_data  (out_data_a),
        .out_sel   (out_sel_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a)
    );

    mux_arb_n #(.WIDTH(8), .NCH(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode_b),
        .sel       (sel_b),
        .in_data   (in_data_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .out_data  (out_data_b),
        .out_sel   (out_sel_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    int          m_ptr [2];
    logic        m_ov  [2];
    logic [31:0] m_od  [2];
    int          m_os  [2];
    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];

    int          cm_nch, cm_sel, cm_os, cm_g, cm_idx;
    logic [15:0] cm_v, cm_rdy, cm_exp_rdy;
    logic [31:0] cm_od, cm_front;
    logic [31:0] cm_d [16];
    logic        cm_ov, cm_ordy, cm_mode, cm_load, cm_found, cm_qempty;
    string       cm_pfx;

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_ptr[u] = 0;
            m_ov[u]  = 1'b0;
            m_od[u]  = 32'd0;
            m_os[u]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < 16; i++) cm_d[i] = 32'd0;
                if (u == 0) begin
                    cm_pfx  = "a";
                    cm_nch  = 16;
                    cm_v    = in_valid_a;
                    cm_rdy  = in_ready_a;
                    cm_od   = out_data_a;
                    cm_os   = int'(out_sel_a);
                    cm_ov   = out_valid_a;
                    cm_ordy = out_ready_a;
                    cm_mode = mode_a;
                    cm_sel  = int'(sel_a);
                    for (int i = 0; i < 16; i++) cm_d[i] = in_data_a[i*32 +: 32];
                end else begin
                    cm_pfx  = "b";
                    cm_nch  = 3;
                    cm_v    = {13'd0, in_valid_b};
                    cm_rdy  = {13'd0, in_ready_b};
                    cm_od   = {24'd0, out_data_b};
                    cm_os   = int'(out_sel_b);
                    cm_ov   = out_valid_b;
                    cm_ordy = out_ready_b;
                    cm_mode = mode_b;
                    cm_sel  = int'(sel_b);
                    for (int i = 0; i < 3; i++) cm_d[i] = {24'd0, in_data_b[i*8 +: 8]};
                end

                // registered outputs against the model's register image
                chk({cm_pfx, "_out_valid"}, 32'(cm_ov), 32'(m_ov[u]));
                chk({cm_pfx, "_out_data"}, cm_od, m_od[u]);
                chk({cm_pfx, "_out_sel"}, cm_os, m_os[u]);

                // a beat retiring now must be the oldest accepted word
                if (!rst && m_ov[u] && cm_ordy) begin
                    cm_front  = 32'hDEAD_BEEF;
                    cm_qempty = 1'b1;
                    if (u == 0 && exp_q_a.size() > 0) begin
                        cm_front  = exp_q_a.pop_front();
                        cm_qempty = 1'b0;
                    end
                    if (u == 1 && exp_q_b.size() > 0) begin
                        cm_front  = exp_q_b.pop_front();
                        cm_qempty = 1'b0;
                    end
                    chk({cm_pfx, "_retire_queue_empty"}, 32'(cm_qempty), 32'd0);
                    chk({cm_pfx, "_retire_data"}, cm_od, cm_front);
                end

                // expected grant this cycle
                cm_load  = !m_ov[u] || cm_ordy;
                cm_found = 1'b0;
                cm_g     = 0;
                if (!rst && cm_load) begin
                    if (!cm_mode) begin
                        if (cm_sel < cm_nch && cm_v[cm_sel]) begin
                            cm_found = 1'b1;
                            cm_g     = cm_sel;
                        end
                    end else begin
                        for (int k = 0; k < cm_nch; k++) begin
                            cm_idx = (m_ptr[u] + k) % cm_nch;
                            if (!cm_found && cm_v[cm_idx]) begin
                                cm_found = 1'b1;
                                cm_g     = cm_idx;
                            end
                        end
                    end
                end
                cm_exp_rdy = cm_found ? (16'd1 << cm_g) : 16'd0;
                chk({cm_pfx, "_in_ready"}, 32'(cm_rdy), 32'(cm_exp_rdy));

                // advance the model to the state after the coming edge
                if (rst) begin
                    m_ov[u]  = 1'b0;
                    m_od[u]  = 32'd0;
                    m_os[u]  = 0;
                    m_ptr[u] = 0;
                    if (u == 0) exp_q_a.delete();
                    else exp_q_b.delete();
                end else if (cm_load) begin
                    m_ov[u] = cm_found;
                    if (cm_found) begin
                        m_od[u] = cm_d[cm_g];
                        m_os[u] = cm_g;
                        if (u == 0) exp_q_a.push_back(cm_d[cm_g]);
                        else exp_q_b.push_back(cm_d[cm_g]);
                        if (cm_mode) m_ptr[u] = (cm_g + 1) % cm_nch;
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        int pat;
        rst = ($urandom_range(0, 199) == 0);
        mode_a = 1'($urandom_range(0, 1));
        mode_b = 1'($urandom_range(0, 1));
        sel_a  = 4'($urandom_range(0, 15));
        sel_b  = 2'($urandom_range(0, 3));
        pat = $urandom_range(0, 3);
        case (pat)
            0:       in_valid_a = 16'd0;
            1:       in_valid_a = 16'd1 << $urandom_range(0, 15);
            2:       in_valid_a = 16'($urandom);
            default: in_valid_a = 16'hFFFF;
        endcase
        in_valid_b  = 3'($urandom_range(0, 7));
        out_ready_a = ($urandom_range(0, 3) != 0);
        out_ready_b = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 16; i++) in_data_a[i*32 +: 32] = $urandom;
        in_data_b = 24'($urandom);
    endtask

    // ---------------- stimulus + literal expectations ----------------
    initial begin
        checks   = 0;
        failures = 0;
        rst         = 1'b1;
        mode_a      = 1'b1;
        sel_a       = 4'd0;
        in_valid_a  = 16'hFFFF;
        out_ready_a = 1'b1;
        mode_b      = 1'b1;
        sel_b       = 2'd0;
        in_valid_b  = 3'b111;
        out_ready_b = 1'b1;
        for (int i = 0; i < 16; i++) in_data_a[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 3; i++) in_data_b[i*8 +: 8] = 8'hB0 + 8'(i);

        // reset held with every channel offering
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready_a", 32'(in_ready_a), 32'd0);
            chk("rst_in_ready_b", 32'(in_ready_b), 32'd0);
            chk("rst_out_valid_a", 32'(out_valid_a), 32'd0);
            chk("rst_out_data_a", out_data_a, 32'd0);
            chk("rst_out_sel_a", 32'(out_sel_a), 32'd0);
        end
        after_edge();
        rst = 1'b0;

        // round-robin over all channels: 0..15,0 (a) and 0,1,2,0 (b)
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            chk("rr_in_ready_a", 32'(in_ready_a), 32'd1 << (k % 16));
            if (k > 0) chk("rr_out_sel_a", 32'(out_sel_a), 32'((k - 1) % 16));
            if (k < 4) chk("rr_in_ready_b", 32'(in_ready_b), 32'd1 << (k % 3));
            if (k > 0 && k < 5) chk("rr_out_sel_b", 32'(out_sel_b), 32'((k - 1) % 3));
        end

        // explicit select of channel 5
        after_edge();
        mode_a = 1'b0;
        sel_a  = 4'd5;
        @(negedge clk);
        chk("sel5_in_ready", 32'(in_ready_a), 32'h0020);
        @(negedge clk);
        chk("sel5_in_ready_2", 32'(in_ready_a), 32'h0020);
        chk("sel5_out_data", out_data_a, 32'hA000_0005);
        chk("sel5_out_sel", 32'(out_sel_a), 32'd5);
        after_edge();
        in_valid_a = 16'hFFDF;
        @(negedge clk);
        chk("sel5_idle_in_ready", 32'(in_ready_a), 32'd0);
        @(negedge clk);
        chk("sel5_idle_out_valid", 32'(out_valid_a), 32'd0);

        // sparse wrap with ptr = 1: 15, 0, 15, 0
        after_edge();
        mode_a     = 1'b1;
        in_valid_a = 16'h8001;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("sparse_in_ready", 32'(in_ready_a), (j % 2 == 0) ? 32'h8000 : 32'h0001);
        end
        after_edge();
        in_valid_a = 16'h0000;
        @(negedge clk);
        chk("empty_in_ready", 32'(in_ready_a), 32'd0);
        @(negedge clk);
        chk("empty_out_valid", 32'(out_valid_a), 32'd0);
        after_edge();
        in_valid_a = 16'hFFFF;
        @(negedge clk);
        chk("ptr_kept_in_ready", 32'(in_ready_a), 32'h0002);

        // backpressure for three cycles while holding channel 1
        after_edge();
        out_ready_a = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready_a), 32'd0);
            chk("bp_out_valid", 32'(out_valid_a), 32'd1);
            chk("bp_out_sel", 32'(out_sel_a), 32'd1);
            chk("bp_out_data", out_data_a, 32'hA000_0001);
        end
        after_edge();
        out_ready_a = 1'b1;
        @(negedge clk);
        chk("bp_resume_in_ready", 32'(in_ready_a), 32'h0004);

        // reset mid-transfer
        after_edge();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready_a), 32'd0);
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid_a), 32'd0);
        chk("midrst_out_sel", 32'(out_sel_a), 32'd0);
        after_edge();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_first_grant", 32'(in_ready_a), 32'h0001);

        // out-of-range explicit select on the 3-channel instance
        after_edge();
        mode_b = 1'b0;
        sel_b  = 2'd3;
        @(negedge clk);
        chk("b_sel3_in_ready", 32'(in_ready_b), 32'd0);
        @(negedge clk);
        chk("b_sel3_out_valid", 32'(out_valid_b), 32'd0);

        // randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            after_edge();
            randomize_inputs();
        end
        after_edge();
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
